// File: rtl/dg_tribus_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dg_tribus_arbiter_if : request/grant/enable bundle of the arbiter   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface dg_tribus_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] en;
  logic [IDX_W-1:0] owner;
  logic             busy;
  logic             preempt;

  modport master (
    input  req,
    output gnt,
    output en,
    output owner,
    output busy,
    output preempt
  );

  modport slave (
    output req,
    input  gnt,
    input  en,
    input  owner,
    input  busy,
    input  preempt
  );
endinterface
`default_nettype wire

// File: rtl/dg_tribus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dg_tribus_arbiter : round-robin owner sequencer for a tristate bus  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module dg_tribus_arbiter #(
  parameter int N_REQ    = 4,
  parameter int IDX_W    = 2,
  parameter int MAX_HOLD = 16,
  parameter int TURN_CYC = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  dg_tribus_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRIVE = 2'd2,
    TURN  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] en_q, en_d;
  logic             busy_q, busy_d;
  logic             preempt_q, preempt_d;
  logic [7:0]       hold_cnt_q, hold_cnt_d;
  logic [3:0]       turn_cnt_q, turn_cnt_d;

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic               pick_vld;
  logic [IDX_W-1:0]   pick_idx;
  logic [N_REQ-1:0]   pick_oh;
  logic               owner_req;
  logic               hold_hit;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input logic [IDX_W-1:0] off);
    logic [IDX_W:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= (IDX_W+1)'(N_REQ)) begin
      sum = sum - (IDX_W+1)'(N_REQ);
    end
    return sum[IDX_W-1:0];
  endfunction

  // Rotating the request vector by ptr turns the round-robin scan into a
  // plain lowest-set-bit search.
  always_comb begin
    req_dbl  = {bus.req, bus.req};
    req_rot  = N_REQ'(req_dbl >> ptr_q);
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        pick_vld = 1'b1;
        pick_idx = wrap_add(ptr_q, IDX_W'(k));
      end
    end
    pick_oh = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
  end

  // gnt_q is one-hot on the owner in SETUP/DRIVE, so it selects req[owner].
  assign owner_req = |(bus.req & gnt_q);
  assign hold_hit  = (MAX_HOLD != 0) && (hold_cnt_q == 8'(MAX_HOLD));

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    gnt_d      = gnt_q;
    en_d       = en_q;
    busy_d     = busy_q;
    preempt_d  = 1'b0;
    hold_cnt_d = hold_cnt_q;
    turn_cnt_d = turn_cnt_q;

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = SETUP;
          gnt_d   = pick_oh;
          owner_d = pick_idx;
          busy_d  = 1'b1;
        end
      end
      SETUP: begin
        if (owner_req) begin
          state_d    = DRIVE;
          en_d       = gnt_q;
          hold_cnt_d = 8'd1;
        end else begin
          state_d    = TURN;
          gnt_d      = '0;
          turn_cnt_d = 4'(TURN_CYC);
        end
      end
      DRIVE: begin
        if (!owner_req || hold_hit) begin
          state_d    = TURN;
          gnt_d      = '0;
          en_d       = '0;
          turn_cnt_d = 4'(TURN_CYC);
          ptr_d      = wrap_add(owner_q, IDX_W'(1));
          preempt_d  = owner_req;
        end else if (hold_cnt_q != 8'hFF) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      TURN: begin
        if (turn_cnt_q <= 4'd1) begin
          if (pick_vld) begin
            state_d = SETUP;
            gnt_d   = pick_oh;
            owner_d = pick_idx;
            busy_d  = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          turn_cnt_d = turn_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        en_d    = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      gnt_q      <= '0;
      en_q       <= '0;
      busy_q     <= 1'b0;
      preempt_q  <= 1'b0;
      hold_cnt_q <= 8'd0;
      turn_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      gnt_q      <= gnt_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
      preempt_q  <= preempt_d;
      hold_cnt_q <= hold_cnt_d;
      turn_cnt_q <= turn_cnt_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.en      = en_q;
  assign bus.owner   = owner_q;
  assign bus.busy    = busy_q;
  assign bus.preempt = preempt_q;

`ifndef SYNTHESIS
  a_en_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(en_q));
  a_en_in_gnt : assert property (@(posedge clk) disable iff (!rst_n)
    ((en_q & ~gnt_q) == '0));
  a_en_no_swap : assert property (@(posedge clk) disable iff (!rst_n)
    (($past(en_q) != '0) && (en_q != '0)) |-> (en_q == $past(en_q)));
  a_no_gnt_idle_turn : assert property (@(posedge clk) disable iff (!rst_n)
    ((state_q == IDLE) || (state_q == TURN)) |-> (gnt_q == '0));
`endif

endmodule
`default_nettype wire

// File: tb/tb_dg_tribus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_dg_tribus_arbiter : directed vectors plus multi-cycle sequences  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_dg_tribus_arbiter;

  logic clk;
  logic rst_n;

  dg_tribus_arbiter_if #(.N_REQ(4), .IDX_W(2)) if_a ();
  dg_tribus_arbiter_if #(.N_REQ(4), .IDX_W(2)) if_b ();
  dg_tribus_arbiter_if #(.N_REQ(4), .IDX_W(2)) if_c ();
  dg_tribus_arbiter_if #(.N_REQ(8), .IDX_W(3)) if_d ();

  dg_tribus_arbiter #(.N_REQ(4), .IDX_W(2), .MAX_HOLD(16), .TURN_CYC(1))
    u_dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  dg_tribus_arbiter #(.N_REQ(4), .IDX_W(2), .MAX_HOLD(3), .TURN_CYC(1))
    u_dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  dg_tribus_arbiter #(.N_REQ(4), .IDX_W(2), .MAX_HOLD(0), .TURN_CYC(3))
    u_dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));
  dg_tribus_arbiter #(.N_REQ(8), .IDX_W(3), .MAX_HOLD(4), .TURN_CYC(1))
    u_dut_d (.clk(clk), .rst_n(rst_n), .bus(if_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [3:0] en;
    logic [1:0] owner;
    logic       busy;
    logic       preempt;
  } vec_t;

  localparam int N_VEC = 17;
  // Fresh requester may wait for 7 full grants of SETUP+DRIVE+TURN; a
  // preempted one additionally sits out its own turnaround cycle.
  localparam int STARVE_BOUND = 7 * (4 + 1 + 1) + 1;

  vec_t       vecs[N_VEC];
  int         checks;
  int         errors;
  int         rr_order[6];
  int         ng, nf, run, gap, bad, extra_pre, grants, max_wait, inv_bad;
  logic [3:0] prev4;
  logic [7:0] prev8, want;
  int         hold_left[8];
  int         wait_cnt[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    rr_order = '{0, 1, 3, 0, 1, 3};
    // {req, gnt, en, owner, busy, preempt}: setup abort, ptr retention, single requester
    vecs = '{
      '{4'b0100, 4'b0100, 4'b0000, 2'd2, 1'b1, 1'b0},
      '{4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b1, 1'b0},
      '{4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0},
      '{4'b1010, 4'b0010, 4'b0000, 2'd1, 1'b1, 1'b0},
      '{4'b1010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0},
      '{4'b1000, 4'b0000, 4'b0000, 2'd1, 1'b1, 1'b0},
      '{4'b1000, 4'b1000, 4'b0000, 2'd3, 1'b1, 1'b0},
      '{4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b1, 1'b0},
      '{4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0},
      '{4'b0100, 4'b0100, 4'b0000, 2'd2, 1'b1, 1'b0},
      '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0},
      '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0},
      '{4'b0101, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0},
      '{4'b0101, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0},
      '{4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b1, 1'b0},
      '{4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0}
      ,'{4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0}
    };

    rst_n    = 1'b0;
    if_a.req = '0;
    if_b.req = '0;
    if_c.req = '0;
    if_d.req = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", {if_a.gnt, if_a.en, if_a.owner, if_a.busy, if_a.preempt}, 32'h0);

    // Asynchronous reset in the middle of a drive phase
    rst_n    = 1'b1;
    if_a.req = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (if_a.en != '0) break;
    end
    check("reach_drive", if_a.en, 4'b0001);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst", {if_a.gnt, if_a.en, if_a.busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rel_gnt_1clk", {if_a.gnt, if_a.en}, {4'b0001, 4'b0000});
    tick();
    check("rel_en_2clk", {if_a.gnt, if_a.en}, {4'b0001, 4'b0001});
    @(negedge clk);
    if_a.req = '0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < N_VEC; i++) begin
      @(negedge clk);
      if_a.req = vecs[i].req;
      tick();
      check($sformatf("vec%0d", i),
            {if_a.gnt, if_a.en, if_a.owner, if_a.busy, if_a.preempt},
            {vecs[i].gnt, vecs[i].en, vecs[i].owner, vecs[i].busy, vecs[i].preempt});
    end

    // Round robin with MAX_HOLD=3 on requesters 0,1,3
    ng = 0; nf = 0; run = 0; gap = 0; extra_pre = 0; prev4 = '0;
    @(negedge clk);
    if_b.req = 4'b1011;
    for (int cyc = 0; cyc < 100 && nf < 6; cyc++) begin
      tick();
      if (if_b.en != '0) begin
        if (prev4 == '0 && ng < 6) begin
          check("rr_owner", if_b.owner, rr_order[ng]);
          check("rr_en", if_b.en, 32'd1 << rr_order[ng]);
          if (ng > 0) check("rr_gap", gap, 2);
          ng++;
          run = 0;
        end
        run++;
        if (if_b.preempt) extra_pre++;
      end else begin
        if (prev4 != '0) begin
          check("rr_hold", run, 3);
          check("rr_preempt", if_b.preempt, 1'b1);
          nf++;
          gap = 0;
        end else if (if_b.preempt) begin
          extra_pre++;
        end
        gap++;
      end
      prev4 = if_b.en;
    end
    check("rr_releases", nf, 6);
    check("rr_extra_preempt", extra_pre, 0);
    @(negedge clk);
    if_b.req = '0;

    // Unlimited hold (MAX_HOLD=0) and a 3-cycle turnaround
    @(negedge clk);
    if_c.req = 4'b0011;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (if_c.en != '0) break;
    end
    check("c_first_en", if_c.en, 4'b0001);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (if_c.en != 4'b0001 || if_c.preempt) bad++;
    end
    check("c_unlimited_hold", bad, 0);
    @(negedge clk);
    if_c.req = 4'b0010;
    gap = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (if_c.en != '0) break;
      gap++;
    end
    check("c_en_gap", gap, 4);
    check("c_second_owner", {if_c.en, if_c.owner}, {4'b0010, 2'd1});
    @(negedge clk);
    if_c.req = '0;

    // Random well-behaved requesters on 8 ports
    want = '0; max_wait = 0; inv_bad = 0; grants = 0; prev8 = '0;
    for (int i = 0; i < 8; i++) begin
      hold_left[i] = 0;
      wait_cnt[i]  = 0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        if (want[i]) begin
          if (if_d.en[i]) begin
            hold_left[i]--;
            if (hold_left[i] == 0) want[i] = 1'b0;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          want[i]      = 1'b1;
          hold_left[i] = int'($urandom_range(1, 6));
        end
      end
      if_d.req = want;
      tick();
      for (int i = 0; i < 8; i++) begin
        if (if_d.req[i] && !if_d.gnt[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
      end
      if (!$onehot0(if_d.en) || !$onehot0(if_d.gnt) || ((if_d.en & ~if_d.gnt) != '0)) inv_bad++;
      if (prev8 == '0 && if_d.en != '0) grants++;
      prev8 = if_d.en;
    end
    check("stress_invariants", inv_bad, 0);
    check("stress_starvation", max_wait <= STARVE_BOUND, 1'b1);
    check("stress_activity", grants > 500, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dg_tribus_arbiter.md
Name: dg_tribus_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared tristate bus built from TRI2-style driver cells. Each driver cell has an active-high output enable (b); the bus value is ~a while b=1 and high-Z otherwise.
- The arbiter grants one requester at a time and drives the enable of that requester's driver.
- It inserts a setup cycle before each enable and a turnaround gap after it, so two drivers are never enabled together.
- It sits between requester logic and the driver cells' enable pins.

Parameters:
- N_REQ, 4: number of requesters/drivers. Legal range 2..16.
- IDX_W, 2: width of the owner index. Must satisfy 2^IDX_W >= N_REQ.
- MAX_HOLD, 16: maximum DRIVE cycles per grant. 0 means unlimited. Legal range 0..255.
- TURN_CYC, 1: number of all-disabled turnaround cycles after each grant. Legal range 1..15.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N_REQ  per-requester bus request, level-sensitive; held high while the bus is wanted.
- gnt  output  N_REQ  one-hot grant, or all zero; tells the requester to present its data on a.
- en  output  N_REQ  one-hot driver enable, or all zero; connects to the driver cells' b pins.
- owner  output  IDX_W  index of the current or most recent grantee.
- busy  output  1  high in SETUP, DRIVE and TURN.
- preempt  output  1  one-cycle pulse when a grant ends because MAX_HOLD was reached.

Behaviour:
- Reset: rst_n low clears all state asynchronously. gnt=0, en=0, owner=0, busy=0, preempt=0, state=IDLE, priority pointer ptr=0, hold_cnt=0, turn_cnt=0. Assertion mid-grant drops en the same instant, with no wait for clk.
- States: IDLE, SETUP, DRIVE, TURN. All outputs are registered.
- Arbitration:
  - Runs in IDLE, and in the last TURN cycle.
  - Picks the first set req bit scanning upward from ptr, wrapping modulo N_REQ.
  - Next edge: state=SETUP, gnt[i]=1, owner=i, busy=1, en stays 0.
  - Latency req -> gnt is 1 cycle from IDLE; req -> en is 2 cycles.
- SETUP: exactly one cycle.
  - If req[owner] is still high: next state DRIVE, en[owner]=1, hold_cnt=1.
  - If req[owner] dropped: next state TURN, gnt=0, en stays 0.
- DRIVE: gnt[owner]=en[owner]=1.
  - Release occurs when req[owner]=0, or when MAX_HOLD!=0 and hold_cnt==MAX_HOLD.
  - On release, next edge: gnt=0, en=0, state=TURN, turn_cnt=TURN_CYC, ptr=(owner+1) mod N_REQ.
  - If the release is due to MAX_HOLD while req[owner] is still high, preempt pulses for 1 cycle, coincident with the first TURN cycle.
  - Otherwise hold_cnt increments, saturating at 255.
- TURN: en=0 and gnt=0 for exactly TURN_CYC cycles; busy=1; turn_cnt decrements.
  - When turn_cnt==1: arbitrate. If any req is set, go to SETUP; otherwise go to IDLE with busy=0.
  - The minimum gap between en falling and the next en rising is TURN_CYC+1 cycles (TURN plus SETUP).
- ptr update: ptr advances only on release from DRIVE. A release from SETUP leaves ptr unchanged.
- Simultaneous events: if req[owner] drops on the same cycle MAX_HOLD is reached, this is a normal release with no preempt. req changes from non-owners during SETUP, DRIVE or TURN are ignored until the next arbitration.
- A preempted requester keeping req high is re-granted only after every other pending requester ahead of it in round-robin order. If it is the only requester, it is re-granted after TURN.
- Invariants, which must be checked by assertions:
  - en is one-hot or zero at all times.
  - en implies gnt (en is a subset of gnt).
  - en never changes directly from one nonzero value to a different nonzero value.
  - gnt is never set in IDLE or TURN.

Test Plan:
- Reset: drive req=4'b1111 while asserting rst_n low mid-DRIVE -> gnt=0, en=0 and busy=0 immediately. After release: gnt=4'b0001 at +1 clk, en=4'b0001 at +2 clk.
- Single requester: req=4'b0100 held for 5 cycles then dropped -> gnt=0100 at t1, en=0100 from t2, release at the edge after req falls, then 1 TURN cycle, then IDLE with busy=0. owner=2 throughout; preempt never pulses.
- Round-robin: req=4'b1011 held, MAX_HOLD=3 -> grant order 0,1,3,0,1,3. Each grant has en high exactly 3 cycles, with preempt pulsing at the end of each. en gap between grants is 2 cycles.
- Setup abort: req[2] pulses high for 1 cycle only -> gnt=0100 for 1 cycle, en stays 0, TURN, IDLE, ptr still 0.
- MAX_HOLD=0 with TURN_CYC=3: req=4'b0011 -> requester 0 owns the bus until req[0] drops. Then 3 TURN cycles, SETUP, and requester 1 gets en. en gap is 4 cycles.
- Random req stress: 10k cycles of random req with N_REQ=8 -> invariant assertions never fire, and no requester holding req starves beyond (N_REQ-1)*(MAX_HOLD+TURN_CYC+1) cycles.
